vga_mem_arbiter: RTL and testbench

- Shares the single CPU/VGA data-memory port between the CPU load/store unit and the VGA pixel fetcher inside CpuMem.
- VGA has priority because it has real-time scan-out deadlines. A starvation counter guarantees the CPU a slot.
- Pipelined: at most one memory access issues per cycle. Read data is routed back to its owner after a fixed memory latency.

---
 rtl/vga_mem_pkg.sv | 18 +
 rtl/rd_tag_pipe.sv | 27 ++
 rtl/vga_mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_vga_mem_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_mem_pkg.sv
// rtl/vga_mem_pkg.sv - shared types and defaults for the VGA/CPU memory arbiter
package vga_mem_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VGA  = 2'd1,
    OWN_CPU  = 2'd2
  } owner_e;

  typedef enum logic {
    PRI_VGA = 1'b0,
    PRI_CPU = 1'b1
  } pri_e;

endpackage

// File: rtl/rd_tag_pipe.sv
// rtl/rd_tag_pipe.sv - RD_LAT-deep shift register of read owner tags
module rd_tag_pipe
  import vga_mem_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  input  owner_e tag_i,
  output owner_e tail_o
);

  owner_e pipe_q [RD_LAT];

  // Clearing the tags is what discards reads that are in flight at reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= OWN_NONE;
    end else begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tail_o = pipe_q[RD_LAT-1];

endmodule

// File: rtl/vga_mem_arbiter.sv
// rtl/vga_mem_arbiter.sv - VGA-priority memory port arbiter with CPU anti-starvation
// Optional stall/grant statistics when ARB_STATS_EN is defined.
module vga_mem_arbiter
  import vga_mem_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int RD_LAT       = 1,
  parameter int CPU_MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]       stat_cpu_stall,
  output logic [15:0]       stat_vga_gnt
`endif
);

  localparam logic [7:0] WAIT_LIM = 8'(CPU_MAX_WAIT - 1);

  pri_e              state_q;
  logic [7:0]        starve_q;
  logic              gnt_vga;
  logic              gnt_cpu;
  owner_e            tag_d;
  owner_e            tail;
  logic [DATA_W-1:0] vga_rdata_q;
  logic [DATA_W-1:0] cpu_rdata_q;

  // Grants are gated by reset so every output reads 0 while it is held.
  always_comb begin
    gnt_vga = 1'b0;
    gnt_cpu = 1'b0;
    if (reset) begin
      if (vga_req && cpu_req) begin
        gnt_cpu = (state_q == PRI_CPU);
        gnt_vga = (state_q == PRI_VGA);
      end else begin
        gnt_vga = vga_req;
        gnt_cpu = cpu_req;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= PRI_VGA;
      starve_q <= 8'd0;
    end else begin
      case (state_q)
        PRI_VGA: begin
          if (gnt_cpu) begin
            starve_q <= 8'd0;
          end else if (cpu_req) begin
            if (starve_q == WAIT_LIM) begin
              state_q  <= PRI_CPU;
              starve_q <= 8'd0;
            end else begin
              starve_q <= starve_q + 8'd1;
            end
          end
        end
        PRI_CPU: begin
          starve_q <= 8'd0;
          if (gnt_cpu) state_q <= PRI_VGA;
        end
        default: state_q <= PRI_VGA;
      endcase
    end
  end

  assign vga_gnt   = gnt_vga;
  assign cpu_gnt   = gnt_cpu;
  assign mem_en    = gnt_vga | gnt_cpu;
  assign mem_we    = gnt_cpu & cpu_we;
  assign mem_addr  = gnt_vga ? vga_addr : (gnt_cpu ? cpu_addr : '0);
  assign mem_wdata = gnt_cpu ? cpu_wdata : '0;

  // CPU writes carry no tag: nothing comes back for them.
  always_comb begin
    tag_d = OWN_NONE;
    if (gnt_vga) tag_d = OWN_VGA;
    else if (gnt_cpu && !cpu_we) tag_d = OWN_CPU;
  end

  rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_tag_pipe (
    .clk    (clk),
    .rst_n  (reset),
    .tag_i  (tag_d),
    .tail_o (tail)
  );

  assign vga_rvalid = (tail == OWN_VGA);
  assign cpu_rvalid = (tail == OWN_CPU);
  assign vga_rdata  = vga_rvalid ? mem_rdata : vga_rdata_q;
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vga_rdata_q <= '0;
      cpu_rdata_q <= '0;
    end else begin
      vga_rdata_q <= vga_rdata;
      cpu_rdata_q <= cpu_rdata;
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] stall_q;
  logic [15:0] vga_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q   <= 16'd0;
      vga_cnt_q <= 16'd0;
    end else begin
      if (cpu_req && !gnt_cpu && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
      if (gnt_vga) vga_cnt_q <= vga_cnt_q + 16'd1;
    end
  end

  assign stat_cpu_stall = stall_q;
  assign stat_vga_gnt   = vga_cnt_q;
`else
`endif

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// tb/tb_vga_mem_arbiter.sv - table-driven bench for vga_mem_arbiter at RD_LAT 1 and 3
module tb_vga_mem_arbiter;

  typedef struct {
    logic        rst;
    logic        vr;
    logic [15:0] va;
    logic        cr;
    logic        cw;
    logic [15:0] ca;
    logic [15:0] cd;
    logic        ev;
    logic        ec;
  } vec_t;

  typedef struct {
    int          due;
    logic        is_cpu;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        vga_req, cpu_req, cpu_we;
  logic [15:0] vga_addr, cpu_addr, cpu_wdata;

  logic [1:0]  vga_gnt_a, cpu_gnt_a, vga_rv_a, cpu_rv_a, mem_en_a, mem_we_a;
  logic [15:0] vga_rd_a [2];
  logic [15:0] cpu_rd_a [2];
  logic [15:0] mem_addr_a [2];
  logic [15:0] mem_wdata_a [2];
`ifdef ARB_STATS_EN
  logic [15:0] stall_a [2];
  logic [15:0] vgn_a [2];
`endif

  always #5 clk = ~clk;

  function automatic logic [15:0] pattern(input logic [15:0] a);
    return a ^ 16'hC35A;
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_dut
    localparam int LAT = (k == 0) ? 1 : 3;
    logic [15:0] store [logic [15:0]];
    logic [15:0] rpipe [LAT];

    always @(posedge clk) begin
      if (mem_en_a[k] && mem_we_a[k]) store[mem_addr_a[k]] = mem_wdata_a[k];
      for (int i = LAT - 1; i > 0; i--) rpipe[i] <= rpipe[i-1];
      if (mem_en_a[k] && !mem_we_a[k])
        rpipe[0] <= store.exists(mem_addr_a[k]) ? store[mem_addr_a[k]] : pattern(mem_addr_a[k]);
      else
        rpipe[0] <= 16'hDEAD;
    end

    vga_mem_arbiter #(
      .ADDR_W       (16),
      .DATA_W       (16),
      .RD_LAT       (LAT),
      .CPU_MAX_WAIT (4)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .vga_req    (vga_req),
      .vga_addr   (vga_addr),
      .vga_gnt    (vga_gnt_a[k]),
      .vga_rvalid (vga_rv_a[k]),
      .vga_rdata  (vga_rd_a[k]),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_gnt    (cpu_gnt_a[k]),
      .cpu_rvalid (cpu_rv_a[k]),
      .cpu_rdata  (cpu_rd_a[k]),
      .mem_en     (mem_en_a[k]),
      .mem_we     (mem_we_a[k]),
      .mem_addr   (mem_addr_a[k]),
      .mem_wdata  (mem_wdata_a[k]),
      .mem_rdata  (rpipe[LAT-1])
`ifdef ARB_STATS_EN
      ,
      .stat_cpu_stall (stall_a[k]),
      .stat_vga_gnt   (vgn_a[k])
`endif
    );
  end

  vec_t        vecs [$];
  exp_t        q0 [$];
  exp_t        q1 [$];
  logic [15:0] exp_store [logic [15:0]];
  logic [15:0] last_v [2];
  logic [15:0] last_c [2];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          exp_stall = 0;
  int          exp_vgn = 0;

  function automatic void add(input logic rst, input logic vr, input logic [15:0] va,
                              input logic cr, input logic cw, input logic [15:0] ca,
                              input logic [15:0] cd, input logic ev, input logic ec);
    vec_t v;
    v.rst = rst; v.vr = vr; v.va = va; v.cr = cr; v.cw = cw;
    v.ca = ca; v.cd = cd; v.ev = ev; v.ec = ec;
    vecs.push_back(v);
  endfunction

  function automatic logic [15:0] exp_data(input logic [15:0] a);
    return exp_store.exists(a) ? exp_store[a] : pattern(a);
  endfunction

  task automatic check(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", name, k, cyc, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    logic have;
    @(posedge clk);
    #1;
    reset     = !v.rst;
    vga_req   = v.vr;
    vga_addr  = v.va;
    cpu_req   = v.cr;
    cpu_we    = v.cw;
    cpu_addr  = v.ca;
    cpu_wdata = v.cd;
    cyc++;
    if (v.rst) begin
      q0.delete();
      q1.delete();
      for (int k = 0; k < 2; k++) begin
        last_v[k] = 16'h0;
        last_c[k] = 16'h0;
      end
      exp_stall = 0;
      exp_vgn   = 0;
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("issue", k,
            {28'h0, vga_gnt_a[k], cpu_gnt_a[k], mem_en_a[k], mem_we_a[k], mem_addr_a[k], mem_wdata_a[k]},
            {28'h0, v.ev, v.ec, v.ev | v.ec, v.ec & v.cw,
             v.ev ? v.va : (v.ec ? v.ca : 16'h0), v.ec ? v.cd : 16'h0});
      have = 1'b0;
      if (k == 0 && q0.size() > 0 && q0[0].due == cyc) begin e = q0.pop_front(); have = 1'b1; end
      if (k == 1 && q1.size() > 0 && q1[0].due == cyc) begin e = q1.pop_front(); have = 1'b1; end
      check("rvalid", k, {62'h0, vga_rv_a[k], cpu_rv_a[k]},
            {62'h0, have && !e.is_cpu, have && e.is_cpu});
      if (have && e.is_cpu) last_c[k] = e.data;
      if (have && !e.is_cpu) last_v[k] = e.data;
      check("rdata", k, {32'h0, vga_rd_a[k], cpu_rd_a[k]}, {32'h0, last_v[k], last_c[k]});
`ifdef ARB_STATS_EN
      check("stat_cpu_stall", k, {48'h0, stall_a[k]}, 64'(exp_stall));
      check("stat_vga_gnt", k, {48'h0, vgn_a[k]}, 64'(exp_vgn));
`endif
    end
    if (!v.rst) begin
      if (v.ev) begin
        q0.push_back('{cyc + 1, 1'b0, exp_data(v.va)});
        q1.push_back('{cyc + 3, 1'b0, exp_data(v.va)});
        exp_vgn++;
      end
      if (v.ec && !v.cw) begin
        q0.push_back('{cyc + 1, 1'b1, exp_data(v.ca)});
        q1.push_back('{cyc + 3, 1'b1, exp_data(v.ca)});
      end
      if (v.ec && v.cw) exp_store[v.ca] = v.cd;
      if (v.cr && !v.ec) exp_stall++;
    end
  endtask

  initial begin
    reset = 1'b0; vga_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    vga_addr = 16'h0; cpu_addr = 16'h0; cpu_wdata = 16'h0;

    // reset held with both requests up: nothing may be granted
    add(1, 1, 16'h0010, 1, 0, 16'h0020, 16'h0, 0, 0);
    add(1, 1, 16'h0010, 1, 0, 16'h0020, 16'h0, 0, 0);
    add(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0);
    // VGA streaming alone
    for (int i = 0; i < 4; i++) add(0, 1, 16'h0100 + 16'(i), 0, 0, 16'h0, 16'h0, 1, 0);
    add(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0);
    // CPU write then read-back
    add(0, 0, 16'h0, 1, 1, 16'h0040, 16'hBEEF, 0, 1);
    add(0, 0, 16'h0, 1, 0, 16'h0040, 16'h0, 0, 1);
    for (int i = 0; i < 3; i++) add(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0);
    // interleaved reads, then one conflict
    add(0, 1, 16'h0200, 0, 0, 16'h0, 16'h0, 1, 0);
    add(0, 0, 16'h0, 1, 0, 16'h0300, 16'h0, 0, 1);
    add(0, 1, 16'h0201, 0, 0, 16'h0, 16'h0, 1, 0);
    add(0, 0, 16'h0, 1, 0, 16'h0301, 16'h0, 0, 1);
    add(0, 1, 16'h0202, 1, 0, 16'h0302, 16'h0, 1, 0);
    add(0, 0, 16'h0, 1, 0, 16'h0302, 16'h0, 0, 1);
    for (int i = 0; i < 3; i++) add(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0);
    // reset with two reads in flight
    add(0, 1, 16'h0400, 0, 0, 16'h0, 16'h0, 1, 0);
    add(0, 0, 16'h0, 1, 0, 16'h0500, 16'h0, 0, 1);
    add(1, 1, 16'h0401, 0, 0, 16'h0, 16'h0, 0, 0);
    add(1, 1, 16'h0401, 0, 0, 16'h0, 16'h0, 0, 0);
    add(0, 1, 16'h0401, 0, 0, 16'h0, 16'h0, 1, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0);
    // continuous contention: 4:1 pattern, 8 stalled cycles in 10
    for (int i = 0; i < 10; i++)
      add(0, 1, 16'h0600, 1, 0, 16'h0700, 16'h0, (i % 5) != 4, (i % 5) == 4);
    add(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0);
    // CPU drops its request while it holds priority, then returns
    for (int i = 0; i < 4; i++) add(0, 1, 16'h0800, 1, 1, 16'h0900, 16'h1234, 1, 0);
    add(0, 1, 16'h0800, 0, 0, 16'h0, 16'h0, 1, 0);
    add(0, 1, 16'h0801, 1, 1, 16'h0900, 16'h1234, 0, 1);
    add(0, 1, 16'h0801, 1, 0, 16'h0900, 16'h0, 1, 0);
    add(0, 0, 16'h0, 1, 0, 16'h0900, 16'h0, 0, 1);
    for (int i = 0; i < 4; i++) add(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0);

    foreach (vecs[i]) apply(vecs[i]);

    check("drain", 0, 64'(q0.size()), 64'd0);
    check("drain", 1, 64'(q1.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
